// File: rtl/param_bank.sv
// param_bank: signed fixed-point tuning registers stepped by a button pair with
// saturation and hold-to-repeat, plus a direct host load port.
module param_bank #(
    parameter int NUM_PARAMS    = 9,
    parameter int WIDTH         = 24,
    parameter int FRAC          = 8,
    parameter int STEP_W        = 4,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 2,
    parameter logic [NUM_PARAMS*WIDTH-1:0] RESET_VALUES = {
        24'h000000, 24'h000100, 24'h000100, 24'h004000, 24'h004000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000}
) (
    input  logic                        clk_slow,
    input  logic                        reset,
    input  logic [3:0]                  sel,
    input  logic [STEP_W-1:0]           step,
    input  logic                        btn_inc,
    input  logic                        btn_dec,
    input  logic                        ld_en,
    input  logic [3:0]                  ld_sel,
    input  logic [WIDTH-1:0]            ld_value,
    output logic [NUM_PARAMS*WIDTH-1:0] values_flat,
    output logic [WIDTH-1:0]            rd_value,
    output logic                        sel_valid,
    output logic                        step_pulse,
    output logic                        sat
);
    localparam int CW = $clog2(REPEAT_DELAY + 1);
    typedef enum logic [1:0] {IDLE, HOLD, LOCK} state_t;
    state_t state, state_nx;
    logic [CW-1:0] hold_cnt, cnt_nx;
    logic [3:0] hold_sel;
    logic dir_up, prev_inc, prev_dec;
    logic inc_edge, dec_edge, start, act_btn, oth_btn, hold_break, cnt_at;
    logic do_step, step_up, step_ok, ovf;
    logic [WIDTH-1:0] bank [16];
    logic [WIDTH-1:0] cur, step_val, stepped;
    logic [WIDTH:0] sum;

    assign inc_edge   = btn_inc & ~prev_inc;
    assign dec_edge   = btn_dec & ~prev_dec;
    assign sel_valid  = {1'b0, sel} < 5'(NUM_PARAMS);
    assign start      = sel_valid & ((inc_edge & ~btn_dec) | (dec_edge & ~btn_inc));
    assign act_btn    = dir_up ? btn_inc : btn_dec;
    assign oth_btn    = dir_up ? btn_dec : btn_inc;
    assign hold_break = oth_btn | ~sel_valid | (sel != hold_sel);
    assign cnt_at     = hold_cnt == CW'(REPEAT_DELAY - 1);
    assign cur        = bank[sel];
    assign rd_value   = sel_valid ? cur : '0;

    // integer field lands at FRAC, two fraction bits just below it
    assign step_val = WIDTH'(step) << (FRAC - 2);
    assign sum      = step_up ? {cur[WIDTH-1], cur} + {1'b0, step_val}
                              : {cur[WIDTH-1], cur} - {1'b0, step_val};
    assign ovf      = sum[WIDTH] != sum[WIDTH-1];
    assign stepped  = ovf ? (sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                          : sum[WIDTH-1:0];
    // a load to the stepped index wins; the step is dropped
    assign step_ok  = do_step & ~(ld_en & (ld_sel == sel));

    always_ff @(posedge clk_slow) begin
        if (reset) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            hold_sel   <= '0;
            dir_up     <= 1'b0;
            prev_inc   <= 1'b1;
            prev_dec   <= 1'b1;
            step_pulse <= 1'b0;
            sat        <= 1'b0;
        end else begin
            state      <= state_nx;
            hold_cnt   <= cnt_nx;
            prev_inc   <= btn_inc;
            prev_dec   <= btn_dec;
            step_pulse <= step_ok;
            sat        <= step_ok & ovf;
            if (state == IDLE && start) begin
                hold_sel <= sel;
                dir_up   <= inc_edge;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = hold_cnt;
        case (state)
            IDLE: begin
                if (inc_edge & dec_edge) state_nx = LOCK;
                else if (start) begin
                    state_nx = HOLD;
                    cnt_nx   = '0;
                end
            end
            HOLD: begin
                if (hold_break) state_nx = LOCK;
                else if (!act_btn) state_nx = IDLE;
                else cnt_nx = cnt_at ? CW'(REPEAT_DELAY - REPEAT_PERIOD) : hold_cnt + 1'b1;
            end
            LOCK: state_nx = (btn_inc | btn_dec) ? LOCK : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        do_step = (state == IDLE) ? start : (state == HOLD) & ~hold_break & act_btn & cnt_at;
        step_up = (state == IDLE) ? inc_edge : dir_up;
    end

    for (genvar i = 0; i < 16; i++) begin : g_reg
        if (i < NUM_PARAMS) begin : g_live
            logic [WIDTH-1:0] r;
            always_ff @(posedge clk_slow) begin
                if (reset) r <= RESET_VALUES[i*WIDTH +: WIDTH];
                else if (ld_en && ld_sel == 4'(i)) r <= ld_value;
                else if (step_ok && sel == 4'(i)) r <= stepped;
            end
            assign bank[i] = r;
            assign values_flat[i*WIDTH +: WIDTH] = r;
        end else begin : g_pad
            assign bank[i] = '0;
        end
    end
endmodule

// File: tb/tb_param_bank.sv
// tb_param_bank: scoreboard bench for param_bank; expected step results are queued
// at stimulus time and matched against each step_pulse.
module tb_param_bank;
    localparam int N = 9;
    localparam int W = 24;

    logic clk_slow = 1'b0;
    logic reset = 1'b1;
    logic [3:0] sel = '0, step = '0, ld_sel = '0;
    logic btn_inc = 1'b0, btn_dec = 1'b0, ld_en = 1'b0;
    logic [W-1:0] ld_value = '0;
    logic [N*W-1:0] values_flat;
    logic [W-1:0] rd_value;
    logic sel_valid, step_pulse, sat;

    typedef struct {int idx; logic [W-1:0] val; logic s;} ev_t;
    ev_t sbq[$];
    ev_t mon_e;
    logic [W-1:0] model [N];
    int total = 0, bad = 0;

    param_bank dut (
        .clk_slow(clk_slow), .reset(reset), .sel(sel), .step(step),
        .btn_inc(btn_inc), .btn_dec(btn_dec), .ld_en(ld_en), .ld_sel(ld_sel),
        .ld_value(ld_value), .values_flat(values_flat), .rd_value(rd_value),
        .sel_valid(sel_valid), .step_pulse(step_pulse), .sat(sat));

    always #5 clk_slow = ~clk_slow;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_slow);
    endtask

    task automatic expect_step(input int i, input logic [W-1:0] v, input logic s);
        sbq.push_back('{i, v, s});
        model[i] = v;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) model[i] = '0;
        model[4] = 24'h004000;
        model[5] = 24'h004000;
        model[6] = 24'h000100;
        model[7] = 24'h000100;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) chk($sformatf("%s_r%0d", tag, i), 32'(values_flat[i*W +: W]), 32'(model[i]));
    endtask

    always begin
        @(posedge clk_slow);
        #1;
        if (step_pulse) begin
            if (sbq.size() == 0) chk("extra_step", 32'(step_pulse), 0);
            else begin
                mon_e = sbq.pop_front();
                chk($sformatf("step_r%0d", mon_e.idx), 32'(values_flat[mon_e.idx*W +: W]), 32'(mon_e.val));
                chk("step_sat", 32'(sat), 32'(mon_e.s));
            end
        end else if (sat) chk("sat_alone", 32'(sat), 0);
    end

    initial begin
        model_reset();
        cyc(3);
        reset = 1'b0;
        cyc(2);
        check_all("rst");
        chk("rst_pulse", 32'(step_pulse), 0);
        chk("rst_sat", 32'(sat), 0);

        sel = 4'd6; step = 4'b0101; btn_inc = 1'b1;
        expect_step(6, 24'h000240, 1'b0);
        cyc(1); btn_inc = 1'b0; cyc(2);
        chk("rd_r6", 32'(rd_value), 32'h240);
        chk("valid_r6", 32'(sel_valid), 1);

        sel = 4'd0; step = 4'b0100; btn_dec = 1'b1;
        expect_step(0, 24'hFFFF00, 1'b0);
        expect_step(0, 24'hFFFE00, 1'b0);
        expect_step(0, 24'hFFFD00, 1'b0);
        expect_step(0, 24'hFFFC00, 1'b0);
        cyc(13); btn_dec = 1'b0; cyc(3);
        chk("hold_r0", 32'(values_flat[0 +: W]), 32'hFFFC00);

        ld_en = 1'b1; ld_sel = 4'd2; ld_value = 24'h7FFF00; model[2] = 24'h7FFF00;
        cyc(1); ld_en = 1'b0;
        chk("ld_r2", 32'(values_flat[2*W +: W]), 32'h7FFF00);
        sel = 4'd2; step = 4'b0100; btn_inc = 1'b1;
        expect_step(2, 24'h7FFFFF, 1'b1);
        cyc(1); btn_inc = 1'b0; cyc(2);
        btn_inc = 1'b1;
        expect_step(2, 24'h7FFFFF, 1'b1);
        cyc(1); btn_inc = 1'b0; cyc(2);

        ld_en = 1'b1; ld_sel = 4'd1; ld_value = 24'h800080; model[1] = 24'h800080;
        cyc(1); ld_en = 1'b0;
        sel = 4'd1; step = 4'b1111; btn_dec = 1'b1;
        expect_step(1, 24'h800000, 1'b1);
        cyc(1); btn_dec = 1'b0; cyc(2);

        sel = 4'd12; #1;
        chk("rd_oor", 32'(rd_value), 0);
        chk("valid_oor", 32'(sel_valid), 0);
        btn_inc = 1'b1; cyc(3); btn_inc = 1'b0; cyc(2);
        btn_dec = 1'b1; cyc(3); btn_dec = 1'b0; cyc(2);
        ld_en = 1'b1; ld_sel = 4'd12; ld_value = 24'hABCDEF;
        cyc(1); ld_en = 1'b0; cyc(1);
        check_all("oor");

        sel = 4'd3; step = 4'b0100; btn_inc = 1'b1;
        expect_step(3, 24'h000100, 1'b0);
        cyc(3); sel = 4'd1; cyc(12); btn_inc = 1'b0; cyc(2);
        check_all("lock");
        sel = 4'd3; #1;
        chk("rd_r3", 32'(rd_value), 32'h100);

        cyc(1);
        btn_inc = 1'b1; ld_en = 1'b1; ld_sel = 4'd3; ld_value = 24'h123456; model[3] = 24'h123456;
        cyc(1); ld_en = 1'b0; btn_inc = 1'b0;
        chk("ldwin_pulse", 32'(step_pulse), 0);
        chk("ldwin_r3", 32'(values_flat[3*W +: W]), 32'h123456);
        cyc(2);
        btn_inc = 1'b1; ld_en = 1'b1; ld_sel = 4'd8; ld_value = 24'h000055; model[8] = 24'h000055;
        expect_step(3, 24'h123556, 1'b0);
        cyc(1); ld_en = 1'b0; btn_inc = 1'b0; cyc(2);
        check_all("ldboth");

        sel = 4'd7; step = 4'b0100; btn_inc = 1'b1; reset = 1'b1;
        cyc(2); reset = 1'b0; model_reset();
        cyc(12);
        check_all("rsthold");
        btn_inc = 1'b0; cyc(2);
        btn_inc = 1'b1;
        expect_step(7, 24'h000200, 1'b0);
        cyc(1); btn_inc = 1'b0; cyc(3);

        chk("sb_empty", 32'(sbq.size()), 0);
        check_all("final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
